// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the bus initiator and its neighbours.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer initiator: valid/ready commands in, pipelined NONSEQ/SINGLE
// transfers out, one in-order response per accepted command.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic [31:0]       hwdata,
  input  logic [31:0]       hrdata,
  input  logic              hready,
  input  logic              hresp,
  output logic              busy
);

  // Address-phase registers
  logic              ap_valid_q, ap_valid_d;
  logic [ADDR_W-1:0] ap_addr_q, ap_addr_d;
  logic              ap_write_q, ap_write_d;
  logic [2:0]        ap_size_q, ap_size_d;
  logic [31:0]       ap_wdata_q, ap_wdata_d;
  // Data-phase registers
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [31:0]       dp_wdata_q, dp_wdata_d;
  // Error handling: cancel_q marks a NONSEQ dropped by an ERROR; cancel_rsp_q marks the
  // cycle carrying that dropped command's response.
  logic              cancel_q, cancel_d;
  logic              cancel_rsp_q, cancel_rsp_d;
  // Response registers
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic              err_active;
  logic              err_first;
  logic              accept;
  logic              dp_done;
  logic              cancel_fire;
  logic [2:0]        eff_size;

  // Clear the low address bits that the transfer size makes meaningless.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0]        sz);
    logic [ADDR_W-1:0] r;
    r = a;
    case (sz)
      HSIZE_HALF: r[0]   = 1'b0;
      HSIZE_WORD: r[1:0] = 2'b00;
      default:    r      = a;
    endcase
    return r;
  endfunction

  // Handshake and phase-completion decode.
  always_comb begin
    err_active  = (dp_valid_q & (hresp == HRESP_ERROR)) | cancel_q | cancel_rsp_q;
    err_first   = dp_valid_q & (hresp == HRESP_ERROR) & ~hready & ap_valid_q;
    cmd_ready   = hready & ~err_active;
    accept      = cmd_valid & cmd_ready;
    dp_done     = hready & dp_valid_q;
    // The cancelled response goes out once the errored transfer has left the data phase.
    cancel_fire = cancel_q & ~dp_valid_q;
    eff_size    = (cmd_size > HSIZE_WORD) ? HSIZE_WORD : cmd_size;
  end

  // Next-state for the pipeline, cancel flags and response registers.
  always_comb begin
    ap_valid_d   = ap_valid_q;
    ap_addr_d    = ap_addr_q;
    ap_write_d   = ap_write_q;
    ap_size_d    = ap_size_q;
    ap_wdata_d   = ap_wdata_q;
    dp_valid_d   = dp_valid_q;
    dp_write_d   = dp_write_q;
    dp_wdata_d   = dp_wdata_q;
    cancel_d     = cancel_q;
    cancel_rsp_d = cancel_fire;

    if (hready) begin
      dp_valid_d = ap_valid_q;
      // Keep hwdata stable across idle slots rather than exposing stale address-phase data.
      if (ap_valid_q) begin
        dp_write_d = ap_write_q;
        dp_wdata_d = ap_wdata_q;
      end
      ap_valid_d = accept;
      if (accept) begin
        ap_addr_d  = align_addr(cmd_addr, eff_size);
        ap_write_d = cmd_write;
        ap_size_d  = eff_size;
        ap_wdata_d = cmd_wdata;
      end
    end else if (err_first) begin
      ap_valid_d = 1'b0;
      cancel_d   = 1'b1;
    end

    if (cancel_fire) begin
      cancel_d = 1'b0;
    end

    rsp_valid_d = dp_done | cancel_fire;
    rsp_err_d   = dp_done ? (hresp == HRESP_ERROR) : cancel_fire;
    rsp_rdata_d = (dp_done && !dp_write_q) ? hrdata : 32'h0;
  end

  // State registers; reset abandons any transfer in flight.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ap_valid_q   <= 1'b0;
      ap_addr_q    <= '0;
      ap_write_q   <= 1'b0;
      ap_size_q    <= HSIZE_BYTE;
      ap_wdata_q   <= 32'h0;
      dp_valid_q   <= 1'b0;
      dp_write_q   <= 1'b0;
      dp_wdata_q   <= 32'h0;
      cancel_q     <= 1'b0;
      cancel_rsp_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 32'h0;
    end else begin
      ap_valid_q   <= ap_valid_d;
      ap_addr_q    <= ap_addr_d;
      ap_write_q   <= ap_write_d;
      ap_size_q    <= ap_size_d;
      ap_wdata_q   <= ap_wdata_d;
      dp_valid_q   <= dp_valid_d;
      dp_write_q   <= dp_write_d;
      dp_wdata_q   <= dp_wdata_d;
      cancel_q     <= cancel_d;
      cancel_rsp_q <= cancel_rsp_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign haddr     = ap_addr_q;
  assign htrans    = ap_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite    = ap_write_q;
  assign hsize     = ap_size_q;
  assign hburst    = HBURST_SINGLE;
  assign hprot     = HPROT_VAL;
  assign hwdata    = dp_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = ap_valid_q | dp_valid_q | cancel_q | rsp_valid_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed scenarios followed by a randomized run against a slave and a sequential memory model.
module tb_ahb_lite_master;

  logic        hclk;
  logic        hresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic        busy;

  int checks;
  int failures;

  ahb_lite_master #(
    .ADDR_W   (32),
    .HPROT_VAL(4'b0011)
  ) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_size (cmd_size),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hburst   (hburst),
    .hprot    (hprot),
    .hwdata   (hwdata),
    .hrdata   (hrdata),
    .hready   (hready),
    .hresp    (hresp),
    .busy     (busy)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_size  = sz;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  // Random-phase state: slave view of the bus and the sequential reference model.
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] slave_mem[16];
  logic [31:0] ref_mem[16];
  logic        sl_active, sl_write, sl_err;
  logic [3:0]  sl_idx;
  int          sl_wait;
  logic        last_acc_err;
  logic        pre_hready, pre_accept, pre_hwrite, pre_cmd_write;
  logic [1:0]  pre_htrans;
  logic [31:0] pre_haddr, pre_hwdata, pre_cmd_addr, pre_cmd_wdata;

  initial begin
    exp_t        e;
    logic        cancelled;
    logic [3:0]  idx;
    logic        errb;

    checks   = 0;
    failures = 0;
    hresetn  = 1'b0;
    hready   = 1'b1;
    hresp    = 1'b0;
    hrdata   = 32'h0;
    set_cmd(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (2) @(posedge hclk);
    #1;

    // Reset state
    check("rst_htrans", htrans, 2'b00);
    check("rst_haddr", haddr, 32'h0);
    check("rst_hwrite", hwrite, 1'b0);
    check("rst_hsize", hsize, 3'd0);
    check("rst_hwdata", hwdata, 32'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("hburst", hburst, 3'b000);
    check("hprot", hprot, 4'b0011);
    hresetn = 1'b1;
    tick();

    // Single word write
    set_cmd(1'b1, 1'b1, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF);
    #1;
    check("t1_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    check("t1_htrans", htrans, 2'b10);
    check("t1_haddr", haddr, 32'h0000_0104);
    check("t1_hwrite", hwrite, 1'b1);
    check("t1_hsize", hsize, 3'd2);
    check("t1_busy", busy, 1'b1);
    check("t1_rsp_early", rsp_valid, 1'b0);
    tick();
    check("t1_hwdata", hwdata, 32'hDEAD_BEEF);
    check("t1_htrans_idle", htrans, 2'b00);
    check("t1_rsp_early2", rsp_valid, 1'b0);
    tick();
    check("t1_rsp_valid", rsp_valid, 1'b1);
    check("t1_rsp_err", rsp_err, 1'b0);
    check("t1_rsp_rdata", rsp_rdata, 32'h0);
    tick();
    check("t1_rsp_done", rsp_valid, 1'b0);
    check("t1_busy_done", busy, 1'b0);

    // Back-to-back write then read
    set_cmd(1'b1, 1'b1, 3'd2, 32'h10, 32'hA5A5_0001);
    tick();
    set_cmd(1'b1, 1'b0, 3'd2, 32'h14, 32'h0);
    check("t2_w_haddr", haddr, 32'h10);
    check("t2_w_hwrite", hwrite, 1'b1);
    tick();
    cmd_valid = 1'b0;
    hrdata    = 32'hFFFF_0000;
    check("t2_r_htrans", htrans, 2'b10);
    check("t2_r_haddr", haddr, 32'h14);
    check("t2_r_hwrite", hwrite, 1'b0);
    check("t2_w_hwdata", hwdata, 32'hA5A5_0001);
    tick();
    hrdata = 32'h1234_5678;
    check("t2_rsp1_valid", rsp_valid, 1'b1);
    check("t2_rsp1_rdata", rsp_rdata, 32'h0);
    tick();
    check("t2_rsp2_valid", rsp_valid, 1'b1);
    check("t2_rsp2_err", rsp_err, 1'b0);
    check("t2_rsp2_rdata", rsp_rdata, 32'h1234_5678);
    tick();
    check("t2_rsp_done", rsp_valid, 1'b0);

    // Read with 3 wait states, second read frozen in its address phase
    set_cmd(1'b1, 1'b0, 3'd2, 32'h40, 32'h0);
    tick();
    set_cmd(1'b1, 1'b0, 3'd2, 32'h48, 32'h0);
    check("t3_a_haddr", haddr, 32'h40);
    tick();
    cmd_valid = 1'b0;
    hready    = 1'b0;
    hrdata    = 32'hDEAD_0000;
    for (int w = 0; w < 3; w++) begin
      #1;
      check("t3_wait_cmd_ready", cmd_ready, 1'b0);
      check("t3_wait_htrans", htrans, 2'b10);
      check("t3_wait_haddr", haddr, 32'h48);
      check("t3_wait_hsize", hsize, 3'd2);
      check("t3_wait_rsp", rsp_valid, 1'b0);
      tick();
    end
    hready = 1'b1;
    hrdata = 32'hCAFE_F00D;
    check("t3_hold_haddr", haddr, 32'h48);
    tick();
    hrdata = 32'h0BAD_CAFE;
    check("t3_rsp_a_valid", rsp_valid, 1'b1);
    check("t3_rsp_a_rdata", rsp_rdata, 32'hCAFE_F00D);
    check("t3_htrans_idle", htrans, 2'b00);
    tick();
    check("t3_rsp_b_valid", rsp_valid, 1'b1);
    check("t3_rsp_b_rdata", rsp_rdata, 32'h0BAD_CAFE);
    tick();

    // Byte, half and illegal-size writes to unaligned addresses
    set_cmd(1'b1, 1'b1, 3'd0, 32'h203, 32'hAB00_0000);
    tick();
    set_cmd(1'b1, 1'b1, 3'd1, 32'h203, 32'hCDCD_0000);
    check("t4_b_haddr", haddr, 32'h203);
    check("t4_b_hsize", hsize, 3'd0);
    tick();
    set_cmd(1'b1, 1'b1, 3'd7, 32'h207, 32'h1122_3344);
    check("t4_h_haddr", haddr, 32'h202);
    check("t4_h_hsize", hsize, 3'd1);
    tick();
    cmd_valid = 1'b0;
    check("t4_w_haddr", haddr, 32'h204);
    check("t4_w_hsize", hsize, 3'd2);
    check("t4_rsp1", rsp_valid, 1'b1);
    tick();
    check("t4_w_hwdata", hwdata, 32'h1122_3344);
    repeat (3) tick();
    check("t4_idle", busy, 1'b0);

    // ERROR on write A with read B in its address phase
    set_cmd(1'b1, 1'b1, 3'd2, 32'h300, 32'h0F0F_0F0F);
    tick();
    set_cmd(1'b1, 1'b0, 3'd2, 32'h304, 32'h0);
    tick();
    set_cmd(1'b1, 1'b0, 3'd2, 32'h308, 32'h0);
    hready = 1'b0;
    hresp  = 1'b1;
    hrdata = 32'h0;
    #1;
    check("t5_err1_cmd_ready", cmd_ready, 1'b0);
    check("t5_err1_htrans", htrans, 2'b10);
    tick();
    hready = 1'b1;
    #1;
    check("t5_err2_cmd_ready", cmd_ready, 1'b0);
    check("t5_err2_htrans", htrans, 2'b00);
    check("t5_err2_busy", busy, 1'b1);
    tick();
    hresp = 1'b0;
    #1;
    check("t5_rsp_a_valid", rsp_valid, 1'b1);
    check("t5_rsp_a_err", rsp_err, 1'b1);
    check("t5_rsp_a_cmd_ready", cmd_ready, 1'b0);
    check("t5_rsp_a_htrans", htrans, 2'b00);
    tick();
    check("t5_rsp_b_valid", rsp_valid, 1'b1);
    check("t5_rsp_b_err", rsp_err, 1'b1);
    check("t5_rsp_b_rdata", rsp_rdata, 32'h0);
    check("t5_rsp_b_cmd_ready", cmd_ready, 1'b0);
    tick();
    check("t5_after_rsp", rsp_valid, 1'b0);
    check("t5_after_htrans", htrans, 2'b00);
    check("t5_after_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    check("t5_c_htrans", htrans, 2'b10);
    check("t5_c_haddr", haddr, 32'h308);
    tick();
    hrdata = 32'h55AA_55AA;
    tick();
    check("t5_c_rsp_valid", rsp_valid, 1'b1);
    check("t5_c_rsp_err", rsp_err, 1'b0);
    check("t5_c_rsp_rdata", rsp_rdata, 32'h55AA_55AA);
    tick();

    // Reset during a wait-stated read
    set_cmd(1'b1, 1'b0, 3'd2, 32'h500, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    hready = 1'b0;
    hrdata = 32'h7777_7777;
    tick();
    check("t6_busy_wait", busy, 1'b1);
    #2;
    hresetn = 1'b0;
    #1;
    check("t6_rst_htrans", htrans, 2'b00);
    check("t6_rst_haddr", haddr, 32'h0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_rsp", rsp_valid, 1'b0);
    tick();
    hready  = 1'b1;
    hresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_no_rsp", rsp_valid, 1'b0);
    end
    set_cmd(1'b1, 1'b1, 3'd2, 32'h600, 32'h1357_9BDF);
    tick();
    cmd_valid = 1'b0;
    check("t6_new_htrans", htrans, 2'b10);
    tick();
    check("t6_new_hwdata", hwdata, 32'h1357_9BDF);
    tick();
    check("t6_new_rsp", rsp_valid, 1'b1);
    check("t6_new_rsp_err", rsp_err, 1'b0);
    tick();

    // Randomized traffic with wait states and ERROR responses
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = 32'hA500_0000 ^ (i * 32'h0101_0101);
      ref_mem[i]   = 32'hA500_0000 ^ (i * 32'h0101_0101);
    end
    sl_active    = 1'b0;
    sl_write     = 1'b0;
    sl_err       = 1'b0;
    sl_idx       = 4'd0;
    sl_wait      = 0;
    last_acc_err = 1'b0;
    pre_accept   = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (sl_active) begin
        hresp  = sl_err;
        hready = (sl_wait == 0);
        if (sl_wait != 0) hrdata = $urandom;
        else if (sl_err) hrdata = 32'h0;
        else if (sl_write) hrdata = $urandom;
        else hrdata = slave_mem[sl_idx];
      end else begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = $urandom;
      end
      if (cyc < 2900) begin
        if (!cmd_valid || pre_accept) begin
          idx  = 4'($urandom_range(0, 15));
          errb = ($urandom_range(0, 6) == 0);
          cmd_valid = ($urandom_range(0, 3) != 0);
          cmd_write = 1'($urandom_range(0, 1));
          cmd_size  = 3'($urandom_range(2, 7));
          cmd_addr  = 32'h1000 + {25'd0, errb, idx, 2'($urandom_range(0, 3))};
          cmd_wdata = $urandom;
        end
      end else begin
        cmd_valid = 1'b0;
      end
      #1;
      if (!hready) check("rnd_stall_cmd_ready", cmd_ready, 1'b0);
      pre_hready    = hready;
      pre_accept    = cmd_valid & cmd_ready;
      pre_htrans    = htrans;
      pre_haddr     = haddr;
      pre_hwrite    = hwrite;
      pre_hwdata    = hwdata;
      pre_cmd_addr  = cmd_addr;
      pre_cmd_write = cmd_write;
      pre_cmd_wdata = cmd_wdata;
      @(posedge hclk);
      if (pre_hready) begin
        if (sl_active && sl_write && !sl_err) slave_mem[sl_idx] = pre_hwdata;
        sl_active = 1'b0;
        if (pre_htrans == 2'b10) begin
          sl_active = 1'b1;
          sl_idx    = pre_haddr[5:2];
          sl_err    = pre_haddr[6];
          sl_write  = pre_hwrite;
          sl_wait   = sl_err ? 1 : int'($urandom_range(0, 2));
        end
        if (pre_accept) begin
          // A command taken while an erroring transfer enters its data phase is cancelled.
          cancelled = last_acc_err;
          e.err     = pre_cmd_addr[6] | cancelled;
          if (e.err) begin
            e.rdata = 32'h0;
          end else if (pre_cmd_write) begin
            ref_mem[pre_cmd_addr[5:2]] = pre_cmd_wdata;
            e.rdata = 32'h0;
          end else begin
            e.rdata = ref_mem[pre_cmd_addr[5:2]];
          end
          exp_q.push_back(e);
          last_acc_err = pre_cmd_addr[6] & ~cancelled;
        end else begin
          last_acc_err = 1'b0;
        end
      end else if (sl_active && sl_wait > 0) begin
        sl_wait--;
      end
      #1;
      check("rnd_htrans_legal", 32'(htrans[0]), 32'h0);
      if (htrans == 2'b10) begin
        check("rnd_haddr_align", 32'(haddr[1:0]), 32'h0);
        check("rnd_hsize_word", hsize, 3'd2);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_rsp_err", rsp_err, e.err);
          check("rnd_rsp_rdata", rsp_rdata, e.rdata);
        end
      end
    end
    check("rnd_pending_rsp", exp_q.size(), 32'd0);
    check("rnd_final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
